sigma_delta_adc: RTL and testbench

//  Receive-side counterpart of the audio sigma-delta DAC: digitises an external comparator bitstream.

---
 rtl/sigma_delta_adc.sv | 136 +++++++++++++
 tb/tb_sigma_delta_adc.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sigma_delta_adc.sv
// Sigma-delta ADC back end: bitstream synchroniser, 1-bit feedback register and sinc2 CIC decimator.
// Optional ready/valid output handshake with sticky OVERRUN is enabled by defining SDADC_HANDSHAKE_EN.
module sigma_delta_adc #(
  parameter int LOG2R = 8,
  parameter int OUTW  = 16
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            CEN,
  input  logic            BITin,
  output logic            FBout,
  output logic [OUTW-1:0] ADCout,
  output logic            ADCvalid
`ifdef SDADC_HANDSHAKE_EN
  ,
  input  logic            ADCready,
  output logic            OVERRUN
`endif
);

  localparam int W  = 2 * LOG2R + 1;
  localparam int YW = 2 * LOG2R;

  typedef logic [W-1:0] acc_t;

  logic             s1_q, s1_d, s2_q, s2_d;
  logic             fb_q, fb_d;
  acc_t             i1_q, i1_d, i2_q, i2_d;
  acc_t             i2d_q, i2d_d, c1d_q, c1d_d;
  logic [LOG2R-1:0] cnt_q, cnt_d;
  logic [1:0]       warm_q, warm_d;
  logic [OUTW-1:0]  out_q, out_d;
  logic             valid_q, valid_d;
`ifdef SDADC_HANDSHAKE_EN
  logic             ovr_q, ovr_d;
`endif

  acc_t             c1_n, y_n;
  logic [YW-1:0]    ys;
  logic             tick, sample;

  always_comb begin
    // NOTE: every signal gets its default first so no path leaves it unassigned (no latch inference).
    s1_d    = BITin;
    s2_d    = s1_q;
    fb_d    = fb_q;
    i1_d    = i1_q;
    i2_d    = i2_q;
    i2d_d   = i2d_q;
    c1d_d   = c1d_q;
    cnt_d   = cnt_q;
    warm_d  = warm_q;
    out_d   = out_q;
    valid_d = valid_q;
`ifdef SDADC_HANDSHAKE_EN
    ovr_d   = ovr_q;
`endif

    tick   = CEN && (&cnt_q);
    sample = tick && (warm_q == 2'd2);

    // Comb stages are exact modulo 2**W, so integrator wrap-around cancels out.
    c1_n = i2_q - i2d_q;
    y_n  = c1_n - c1d_q;
    // Only the all-ones density reaches R*R, which needs the extra top bit; clamp it to full scale.
    ys   = y_n[W-1] ? '1 : y_n[YW-1:0];

    if (CEN) begin
      fb_d  = s2_q;
      i1_d  = i1_q + acc_t'(s2_q);
      i2_d  = i2_q + i1_q;
      cnt_d = cnt_q + LOG2R'(1);
    end

    if (tick) begin
      i2d_d = i2_q;
      c1d_d = c1_n;
      if (warm_q != 2'd2) warm_d = warm_q + 2'd1;
    end

    if (sample) out_d = OUTW'(ys) << (OUTW - YW);

`ifdef SDADC_HANDSHAKE_EN
    if (valid_q && ADCready) valid_d = 1'b0;
    if (sample) begin
      valid_d = 1'b1;
      if (valid_q && !ADCready) ovr_d = 1'b1;
    end
`else
    valid_d = sample;
`endif
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      fb_q    <= 1'b0;
      i1_q    <= '0;
      i2_q    <= '0;
      i2d_q   <= '0;
      c1d_q   <= '0;
      cnt_q   <= '0;
      warm_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
`ifdef SDADC_HANDSHAKE_EN
      ovr_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbours.
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      fb_q    <= fb_d;
      i1_q    <= i1_d;
      i2_q    <= i2_d;
      i2d_q   <= i2d_d;
      c1d_q   <= c1d_d;
      cnt_q   <= cnt_d;
      warm_q  <= warm_d;
      out_q   <= out_d;
      valid_q <= valid_d;
`ifdef SDADC_HANDSHAKE_EN
      ovr_q   <= ovr_d;
`endif
    end
  end

  assign FBout    = fb_q;
  assign ADCout   = out_q;
  assign ADCvalid = valid_q;
`ifdef SDADC_HANDSHAKE_EN
  assign OVERRUN  = ovr_q;
`endif

endmodule

// File: tb/tb_sigma_delta_adc.sv
// Directed bench for sigma_delta_adc (LOG2R=8, OUTW=16) with hand-derived sinc2 outputs.
// Handshake checks are compiled in when SDADC_HANDSHAKE_EN is defined.
module tb_sigma_delta_adc;

  typedef enum int {M_ZERO, M_ONE, M_ALT, M_QUARTER, M_ONE_CEN4, M_MANUAL} mode_e;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        CEN;
  logic        BITin;
  logic        FBout;
  logic [15:0] ADCout;
  logic        ADCvalid;
`ifdef SDADC_HANDSHAKE_EN
  logic        ADCready;
  logic        OVERRUN;
`endif

  int    n_checks = 0;
  int    n_errors = 0;
  mode_e mode     = M_ZERO;
  int    ph       = 0;

  sigma_delta_adc #(.LOG2R(8), .OUTW(16)) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .CEN      (CEN),
    .BITin    (BITin),
    .FBout    (FBout),
    .ADCout   (ADCout),
    .ADCvalid (ADCvalid)
`ifdef SDADC_HANDSHAKE_EN
    ,
    .ADCready (ADCready),
    .OVERRUN  (OVERRUN)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock step: wait for the falling edge, then drive the inputs for the next rising edge.
  task automatic cycle();
    @(negedge CLK);
    ph++;
    case (mode)
      M_ZERO:     begin BITin = 1'b0;              CEN = 1'b1; end
      M_ONE:      begin BITin = 1'b1;              CEN = 1'b1; end
      M_ALT:      begin BITin = ph[0];             CEN = 1'b1; end
      M_QUARTER:  begin BITin = (ph[1:0] == 2'd0); CEN = 1'b1; end
      M_ONE_CEN4: begin BITin = 1'b1;              CEN = (ph[1:0] == 2'd0); end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    cycle();
    cycle();
    RESET_N = 1'b1;
  endtask

  // Returns the number of rising edges until ADCvalid is seen, or -1 on timeout.
  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (n < limit) begin
      cycle();
      n++;
      if (ADCvalid) return;
    end
    n = -1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int bad;
    RESET_N = 1'b0;
    CEN     = 1'b0;
    BITin   = 1'b0;
`ifdef SDADC_HANDSHAKE_EN
    ADCready = 1'b1;
`endif
    #1;
    check("reset_adcout", ADCout, 16'h0000);
    check("reset_valid", ADCvalid, 1'b0);
    check("reset_fbout", FBout, 1'b0);
`ifdef SDADC_HANDSHAKE_EN
    check("reset_overrun", OVERRUN, 1'b0);
`endif

    // All-zeros input: first sample on the 3rd tick.
    mode = M_ZERO;
    do_reset();
    wait_valid(2000, n);
    check("zero_latency", n, 768);
    check("zero_adcout", ADCout, 16'h0000);
    check("zero_fbout", FBout, 1'b0);
    cycle();
    check("zero_pulse", ADCvalid, 1'b0);

    // All-ones input: feedback delay and saturation.
    mode = M_ZERO;
    do_reset();
    repeat (4) cycle();
    mode = M_ONE;
    cycle();
    cycle();
    cycle();
    check("fb_delay2", FBout, 1'b0);
    cycle();
    check("fb_delay3", FBout, 1'b1);
    wait_valid(2000, n);
    check("ones_adcout", ADCout, 16'hFFFF);
    wait_valid(300, n);
    check("ones_period", n, 256);
    check("ones_adcout2", ADCout, 16'hFFFF);

    // Half density, held long enough for I2 to wrap many times.
    mode = M_ALT;
    do_reset();
    wait_valid(2000, n);
    check("alt_adcout", ADCout, 16'h8000);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      wait_valid(300, n);
      if (n != 256 || ADCout !== 16'h8000) bad++;
    end
    check("alt_wrap_steady", bad, 0);

    // Quarter density.
    mode = M_QUARTER;
    do_reset();
    wait_valid(2000, n);
    check("quarter_adcout", ADCout, 16'h4000);

    // Clock enable 1-in-4.
    mode = M_ONE_CEN4;
    do_reset();
    wait_valid(5000, n);
    check("cen4_adcout", ADCout, 16'hFFFF);
    wait_valid(2000, n);
    check("cen4_period", n, 1024);
    check("cen4_adcout2", ADCout, 16'hFFFF);
    cycle();
    check("cen4_pulse", ADCvalid, 1'b0);

    // Asynchronous reset mid-frame, then full warm-up again.
    mode = M_ONE;
    do_reset();
    wait_valid(2000, n);
    check("rst_pre_adcout", ADCout, 16'hFFFF);
    repeat (100) cycle();
    check("rst_pre_fbout", FBout, 1'b1);
    #2 RESET_N = 1'b0;
    #1;
    check("rst_async_adcout", ADCout, 16'h0000);
    check("rst_async_fbout", FBout, 1'b0);
    check("rst_async_valid", ADCvalid, 1'b0);
    cycle();
    cycle();
    RESET_N = 1'b1;
    wait_valid(2000, n);
    check("rst_warmup", n, 768);

    // Ones through cycle 767, frozen, then zeros: sample 4 = 0x817F, sample 5 = 0x0001.
    mode = M_ONE;
    do_reset();
    wait_valid(2000, n);
    check("frz_latency", n, 768);
    mode  = M_MANUAL;
    CEN   = 1'b0;
    BITin = 1'b0;
    cycle();
    check("frz_valid_drop", ADCvalid, 1'b0);
`ifdef SDADC_HANDSHAKE_EN
    ADCready = 1'b0;
`endif
    repeat (3) cycle();
    check("frz_fbout_held", FBout, 1'b1);
    CEN = 1'b1;
    wait_valid(400, n);
    check("frz_period", n, 256);
    check("frz_sample4", ADCout, 16'h817F);
`ifdef SDADC_HANDSHAKE_EN
    check("hs_no_overrun", OVERRUN, 1'b0);
    n = -1;
    for (int i = 1; i <= 400; i++) begin
      cycle();
      if (ADCvalid !== 1'b1) bad++;
      if (OVERRUN) begin
        n = i;
        break;
      end
    end
    check("hs_overrun_at_tick", n, 256);
    check("hs_valid_held", ADCvalid, 1'b1);
    check("hs_overwrite", ADCout, 16'h0001);
    ADCready = 1'b1;
    cycle();
    check("hs_valid_clear", ADCvalid, 1'b0);
    check("hs_overrun_sticky", OVERRUN, 1'b1);
`else
    wait_valid(400, n);
    check("frz_period5", n, 256);
    check("frz_sample5", ADCout, 16'h0001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
